// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, the FSM
// state encoding, the default bus timeout and funct3 decode helpers.
package load_store_unit_pkg;

    localparam int LSU_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    // Reserved codes 011/110/111 fall through to a full word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_B;
            F3_LH, F3_LHU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Load extraction: picks the byte/half addressed by the low address bits out
// of the returned word and sign- or zero-extends it to 32 bits.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lo,
    input  lsu_size_t   size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_B:    data = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    data = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-memory access with bus timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and flag misalign.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access; captures a request when req_valid=1
// WAIT  | dmem_req held with frozen bus fields until ack or timeout
// DONE  | one-cycle completion: lsu_done, optional bus_err / misalign
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic               mem_we,
    input  logic [2:0]         funct3,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        rs2_data,
    load_store_unit_if.master  dmem,
    output logic               stall,
    output logic               lsu_done,
    output logic [31:0]        load_data,
    output logic               bus_err,
    output logic               misalign
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t       state_q, state_d;
    logic [31:0]      addr_q;
    logic [1:0]       lo_q;
    logic             we_q;
    lsu_size_t        size_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             mis_q;
    logic [31:0]      load_data_q;

    lsu_size_t        size_in;
    logic             uns_in;
    logic [1:0]       lo_in;
    logic [31:0]      wdata_in;
    logic [3:0]       be_in;
    logic             trap;
    logic [31:0]      aligned_data;
    logic             in_wait;
    logic             capture;

    assign size_in = f3_size(funct3);
    assign uns_in  = f3_unsigned(funct3);

    // Lane steering; the low address bits are forced to natural alignment
    // so the word address and byte enables are always legal.
    always_comb begin
        lo_in    = alu_result[1:0];
        wdata_in = rs2_data;
        be_in    = 4'b1111;
        case (size_in)
            SZ_B: begin
                wdata_in = {4{rs2_data[7:0]}};
                be_in    = 4'b0001 << alu_result[1:0];
            end
            SZ_H: begin
                lo_in    = {alu_result[1], 1'b0};
                wdata_in = {2{rs2_data[15:0]}};
                be_in    = 4'b0011 << {alu_result[1], 1'b0};
            end
            default: begin
                lo_in    = 2'b00;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((size_in == SZ_H) && alu_result[0]) ||
                  ((size_in == SZ_W) && (alu_result[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = trap ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem.dmem_ack || (cnt_q == '0)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_wait = (state_q == ST_WAIT);
    assign capture = (state_q == ST_IDLE) && req_valid;

    load_align u_load_align (
        .rdata (dmem.dmem_rdata),
        .lo    (lo_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (aligned_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            lo_q        <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_W;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= {alu_result[31:2], 2'b00};
                lo_q    <= lo_in;
                we_q    <= mem_we;
                size_q  <= size_in;
                uns_q   <= uns_in;
                wdata_q <= wdata_in;
                be_q    <= be_in;
                cnt_q   <= CNT_LOAD;
                err_q   <= 1'b0;
                mis_q   <= trap;
            end else if (in_wait) begin
                // Ack wins over a timeout expiring in the same cycle.
                if (dmem.dmem_ack) begin
                    if (!we_q) load_data_q <= aligned_data;
                end else if (cnt_q == '0) begin
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign dmem.dmem_req   = in_wait;
    assign dmem.dmem_we    = in_wait & we_q;
    assign dmem.dmem_addr  = in_wait ? addr_q  : '0;
    assign dmem.dmem_wdata = in_wait ? wdata_q : '0;
    assign dmem.dmem_be    = in_wait ? be_q    : '0;

    assign stall     = capture | in_wait;
    assign lsu_done  = (state_q == ST_DONE);
    assign bus_err   = lsu_done & err_q;
    assign misalign  = lsu_done & mis_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses replayed against a small memory
// responder, completion results checked through a scoreboard queue.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2_data = '0;
    logic        stall, lsu_done, bus_err, misalign;
    logic [31:0] load_data;

    load_store_unit_if dmem_if();

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .alu_result (alu_result),
        .rs2_data   (rs2_data),
        .dmem       (dmem_if),
        .stall      (stall),
        .lsu_done   (lsu_done),
        .load_data  (load_data),
        .bus_err    (bus_err),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          wt;       // WAIT cycle carrying the ack, 0 = never
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        upd;      // access updates load_data
        logic [31:0] e_load;
        logic        e_err;
        logic        e_mis;
        int          e_lat;    // cycles from request to lsu_done
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic        err;
        logic        mis;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_load = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   cyc;
        int   stall_cnt;
        int   req_cnt;
        bit   done_seen;
        @(negedge clk);
        req_valid  = 1'b1;
        mem_we     = v.we;
        funct3     = v.f3;
        alu_result = v.addr;
        rs2_data   = v.rs2;
        e.load = v.upd ? v.e_load : last_load;
        e.err  = v.e_err;
        e.mis  = v.e_mis;
        if (v.upd) last_load = v.e_load;
        sb.push_back(e);
        #1;
        chk("stall_on_req", stall, 1);
        chk("req_in_idle", dmem_if.dmem_req, 0);
        stall_cnt = 1;
        req_cnt   = 0;
        cyc       = 0;
        done_seen = 0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (stall) stall_cnt++;
            if (dmem_if.dmem_req) begin
                req_cnt++;
                chk("dmem_addr", dmem_if.dmem_addr, v.e_addr);
                chk("dmem_be", dmem_if.dmem_be, v.e_be);
                chk("dmem_we", dmem_if.dmem_we, v.we);
                if (v.we) chk("dmem_wdata", dmem_if.dmem_wdata, v.e_wdata);
            end
            if (lsu_done) begin
                done_seen = 1;
                chk("stall_in_done", stall, 0);
                chk("latency", cyc, v.e_lat);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk("load_data", load_data, got.load);
                    chk("bus_err", bus_err, got.err);
                    chk("misalign", misalign, got.mis);
                end
            end
            // Inputs other than the handshake are scrambled while busy.
            req_valid  = dmem_if.dmem_req ? 1'($urandom) : 1'b0;
            mem_we     = 1'($urandom);
            funct3     = 3'($urandom);
            alu_result = $urandom;
            rs2_data   = $urandom;
            dmem_if.dmem_ack   = dmem_if.dmem_req && (v.wt != 0) && (req_cnt == v.wt) && !done_seen;
            dmem_if.dmem_rdata = dmem_if.dmem_ack ? v.rdata : $urandom;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("stall_cycles", stall_cnt, v.e_lat);
        chk("req_cycles", req_cnt, v.e_lat - 1);
        req_valid = 1'b0;
        dmem_if.dmem_ack = 1'b0;
        @(negedge clk);
        chk("done_pulse", lsu_done, 0);
        chk("req_after", dmem_if.dmem_req, 0);
        chk("err_after", bus_err, 0);
        chk("mis_after", misalign, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    f3      addr          rs2           rdata        wt  e_addr        e_wdata       be     upd   e_load        err   mis  lat
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 3, 32'h0000_0100, 32'h0,        4'h8, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 3, 32'h0000_0100, 32'h0,        4'h8, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        2, 32'h0000_0100, 32'hABCD_ABCD, 4'hC, 1'b0, 32'h0,        1'b0, 1'b0, 3});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A, 32'h0,        1, 32'h0000_0100, 32'h5A5A_5A5A, 4'h2, 1'b0, 32'h0,        1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 2, 32'h0000_0100, 32'h0,        4'hC, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F234, 1, 32'h0000_0100, 32'h0,        4'h3, 1'b1, 32'h0000_F234, 1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h1234_5678, 5, 32'h0000_0104, 32'h0,        4'hF, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 6});
        vecs.push_back('{1'b1, 3'b011, 32'h0000_0108, 32'hCAFE_F00D, 32'h0,        1, 32'h0000_0108, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b110, 32'h0000_010C, 32'h0,        32'hA5A5_0001, 1, 32'h0000_010C, 32'h0,        4'hF, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0110, 32'h0,        32'h0,        0, 32'h0000_0110, 32'h0,        4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 17});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0114, 32'h0,        32'h0BAD_C0DE, 16, 32'h0000_0114, 32'h0,       4'hF, 1'b1, 32'h0BAD_C0DE, 1'b0, 1'b0, 17});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h7FFF_0000, 1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h55AA_55AA, 1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0106, 32'h0102_0304, 32'h0,        1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1});
`else
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h7FFF_0000, 1, 32'h0000_0100, 32'h0,        4'hC, 1'b1, 32'h0000_7FFF, 1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h55AA_55AA, 1, 32'h0000_0100, 32'h0,        4'hF, 1'b1, 32'h55AA_55AA, 1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0106, 32'h0102_0304, 32'h0,        1, 32'h0000_0104, 32'h0102_0304, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 2});
`endif

        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = '0;
        #12;
        chk("rst_req", dmem_if.dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_load", load_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Ack while idle must not complete anything or touch load_data.
        @(negedge clk);
        dmem_if.dmem_ack   = 1'b1;
        dmem_if.dmem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("idle_ack_done", lsu_done, 0);
            chk("idle_ack_load", load_data, last_load);
            chk("idle_ack_req", dmem_if.dmem_req, 0);
        end
        dmem_if.dmem_ack = 1'b0;

        // Reset in the middle of WAIT aborts the access without replay.
        @(negedge clk);
        req_valid  = 1'b1;
        mem_we     = 1'b0;
        funct3     = 3'b010;
        alu_result = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_wait_req", dmem_if.dmem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_req", dmem_if.dmem_req, 0);
        chk("abort_stall", stall, 0);
        chk("abort_done", lsu_done, 0);
        chk("abort_load", load_data, 0);
        last_load = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_replay_req", dmem_if.dmem_req, 0);
            chk("no_replay_done", lsu_done, 0);
        end
        run_vec(vecs[1]);
        run_vec(vecs[0]);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
